// File: rtl/mem_copy_engine_if.sv
// Copy-engine handshake and memory-port bundle.
// The engine drives it through `master`; the requester and the RAM use `slave`.
interface mem_copy_engine_if #(
  parameter int unsigned SIZE = 14
);
  logic            start;
  logic [SIZE-1:0] src_addr;
  logic [SIZE-1:0] dst_addr;
  logic [SIZE-1:0] len;
  logic            busy;
  logic            done;
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;

  modport master (
    input  start, src_addr, dst_addr, len, data_fromRAM,
    output busy, done, wrEn, addr_toRAM, data_toRAM
  );

  modport slave (
    output start, src_addr, dst_addr, len, data_fromRAM,
    input  busy, done, wrEn, addr_toRAM, data_toRAM
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy initiator: one read cycle, then one write cycle per word.
// The RAM returns read data one cycle after the address, so each WR forwards the word read in the RD before it.
module mem_copy_engine #(
  parameter int unsigned SIZE = 14
) (
  input  logic              clk,
  input  logic              rst,
  mem_copy_engine_if.master bus
);

  localparam int unsigned CW = SIZE + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [SIZE-1:0] r_i, w_i_nxt;
  logic [SIZE-1:0] r_src, w_src_nxt;
  logic [SIZE-1:0] r_dst, w_dst_nxt;
  logic [SIZE-1:0] r_len, w_len_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_wr_en, w_wr_en_nxt;
  logic [SIZE-1:0] r_addr, w_addr_nxt;
  logic [31:0]     w_data_to_ram;

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next state; outputs are derived from the next state so they register in step with it.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_src_nxt   = bus.src_addr;
          w_dst_nxt   = bus.dst_addr;
          w_len_nxt   = bus.len;
          w_i_nxt     = '0;
          w_state_nxt = (bus.len != '0) ? S_RD : S_DONE;
        end
      end
      S_RD:   w_state_nxt = S_WR;
      S_WR: begin
        w_i_nxt     = r_i + SIZE'(1);
        w_state_nxt = ((CW'(r_i) + CW'(1)) < CW'(r_len)) ? S_RD : S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt  = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_wr_en_nxt = (w_state_nxt == S_WR);
    w_addr_nxt  = '0;
    if (w_state_nxt == S_RD) begin
      w_addr_nxt = w_src_nxt + w_i_nxt;
    end else if (w_state_nxt == S_WR) begin
      w_addr_nxt = w_dst_nxt + w_i_nxt;
    end
  end

  // Read data only arrives during WR, so it is forwarded rather than registered.
  assign w_data_to_ram = (r_state == S_WR) ? bus.data_fromRAM : 32'd0;

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.wrEn       = r_wr_en;
  assign bus.addr_toRAM = r_addr;
  assign bus.data_toRAM = w_data_to_ram;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural registered-read RAM.
// Copies are checked for data, done timing, write count, busy count, overlap, start-ignore and async reset.
module tb_mem_copy_engine;
  localparam int unsigned SIZE = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_copy_engine_if #(.SIZE(SIZE)) bus ();

  mem_copy_engine #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // RAM model: read returns the pre-write value; the backdoor port takes priority for preloads.
  logic [31:0]     mem [0:(1<<SIZE)-1];
  logic            bd_we = 1'b0;
  logic [SIZE-1:0] bd_addr = '0;
  logic [31:0]     bd_data = '0;

  always @(posedge clk) begin
    bus.data_fromRAM <= mem[bus.addr_toRAM];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.wrEn) mem[bus.addr_toRAM] <= bus.data_toRAM;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = SIZE'(a);
    bd_data = d;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Issue one copy and observe cycles 1..N after the sampling edge until done.
  task automatic run_copy(input int src, input int dst, input int ln, input bit hold,
                          output int done_cyc, output int wr_cnt, output int busy_cnt,
                          output int we_viol);
    bit prev_we;
    done_cyc = 0; wr_cnt = 0; busy_cnt = 0; we_viol = 0; prev_we = 1'b0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.src_addr = SIZE'(src);
    bus.dst_addr = SIZE'(dst);
    bus.len      = SIZE'(ln);
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start    = 1'b0;
      bus.src_addr = ~SIZE'(src);
      bus.dst_addr = ~SIZE'(dst);
      bus.len      = SIZE'(7);
    end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.wrEn) wr_cnt++;
      if (bus.wrEn && prev_we) we_viol++;
      prev_we = bus.wrEn;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  int dc, wc, bc, wv;
  bit seen;

  initial begin
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wren", 32'(bus.wrEn), 32'd0);
    chk("rst_addr", 32'(bus.addr_toRAM), 32'd0);
    chk("rst_data", bus.data_toRAM, 32'd0);
    rst = 1'b1;

    // Basic copy
    poke(100, 6); poke(101, 7); poke(102, 8); poke(203, 32'hDEAD);
    run_copy(100, 200, 3, 1'b0, dc, wc, bc, wv);
    chk("basic_done_cyc", 32'(dc), 32'd7);
    chk("basic_wr_cnt", 32'(wc), 32'd3);
    chk("basic_busy_cnt", 32'(bc), 32'd6);
    chk("basic_we_consec", 32'(wv), 32'd0);
    chk("basic_m200", mem[200], 32'd6);
    chk("basic_m201", mem[201], 32'd7);
    chk("basic_m202", mem[202], 32'd8);
    chk("basic_m203", mem[203], 32'hDEAD);
    @(negedge clk);
    chk("basic_done_pulse", 32'(bus.done), 32'd0);

    // Zero length
    run_copy(10, 20, 0, 1'b0, dc, wc, bc, wv);
    chk("zero_done_cyc", 32'(dc), 32'd1);
    chk("zero_wr_cnt", 32'(wc), 32'd0);
    chk("zero_busy_cnt", 32'(bc), 32'd0);

    // Address wrap
    poke(16382, 32'hA); poke(16383, 32'hB); poke(0, 32'hC); poke(1, 32'hD);
    run_copy(16382, 5, 4, 1'b0, dc, wc, bc, wv);
    chk("wrap_done_cyc", 32'(dc), 32'd9);
    chk("wrap_m5", mem[5], 32'hA);
    chk("wrap_m6", mem[6], 32'hB);
    chk("wrap_m7", mem[7], 32'hC);
    chk("wrap_m8", mem[8], 32'hD);

    // Overlap with start held high
    poke(50, 9); poke(51, 1); poke(52, 2); poke(53, 3);
    run_copy(50, 51, 3, 1'b1, dc, wc, bc, wv);
    chk("ovl_done_cyc", 32'(dc), 32'd7);
    chk("ovl_wr_cnt", 32'(wc), 32'd3);
    chk("ovl_m51", mem[51], 32'd9);
    chk("ovl_m52", mem[52], 32'd9);
    chk("ovl_m53", mem[53], 32'd9);
    @(negedge clk);
    chk("ovl_idle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("ovl_restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    chk("ovl_second_done", 32'(seen), 32'd1);

    // Reset mid-copy
    for (int k = 0; k < 10; k++) poke(300 + k, 32'(300 + k));
    for (int k = 0; k < 5; k++) poke(400 + k, 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = SIZE'(300); bus.dst_addr = SIZE'(400); bus.len = SIZE'(10);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wc = 0;
    for (int c = 0; c < 40 && wc < 3; c++) begin
      @(negedge clk);
      if (bus.wrEn) wc++;
    end
    chk("mid_wr_seen", 32'(wc), 32'd3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_wren", 32'(bus.wrEn), 32'd0);
    chk("mid_addr", 32'(bus.addr_toRAM), 32'd0);
    chk("mid_data", bus.data_toRAM, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.wrEn) seen = 1'b1;
    end
    chk("mid_no_done", 32'(seen), 32'd0);
    rst = 1'b1;
    chk("mid_m400", mem[400], 32'd300);
    chk("mid_m402", mem[402], 32'd302);
    chk("mid_m403", mem[403], 32'd0);
    run_copy(300, 500, 2, 1'b0, dc, wc, bc, wv);
    chk("post_done_cyc", 32'(dc), 32'd5);
    chk("post_m500", mem[500], 32'd300);
    chk("post_m501", mem[501], 32'd301);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: SIZE, 14, word-address width of the memory port; addressable depth is 2**SIZE words of 32 bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port: start  input  1  copy request, sampled on rising edge in IDLE only.
REQ-005 Port: src_addr  input  SIZE  first source word address, captured with start.
REQ-006 Port: dst_addr  input  SIZE  first destination word address, captured with start.
REQ-007 Port: len  input  SIZE  number of words to copy, captured with start; 0 is legal.
REQ-008 Port: busy  output  1  high while a copy is executing (RD/WR states).
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: wrEn  output  1  memory write enable toward the RAM.
REQ-011 Port: addr_toRAM  output  SIZE  memory word address.
REQ-012 Port: data_toRAM  output  32  memory write data.
REQ-013 Port: data_fromRAM  input  32  memory read data, registered inside the RAM: it equals mem[addr_toRAM] as sampled on the previous rising edge, with the old value returned when a write hits that address on the same edge.

Function
REQ-014 The block SHALL be a memory initiator implementing a Moore FSM with states IDLE, RD, WR and DONE.
REQ-015 IDLE: busy=0, done=0, wrEn=0, and addr_toRAM/data_toRAM hold 0; if start=1 the block SHALL capture src_addr, dst_addr and len, clear word index i to 0, and go to RD if len!=0, else DONE.
REQ-016 RD: wrEn=0, addr_toRAM=src+i, busy=1; the block SHALL go to WR on the next edge.
REQ-017 WR: wrEn=1, addr_toRAM=dst+i, data_toRAM=data_fromRAM (the word read in the preceding RD), busy=1; the block SHALL increment i and go to RD if i+1<len, else to DONE.
REQ-018 DONE: done=1, busy=0, wrEn=0 for exactly one cycle; the block SHALL return to IDLE unconditionally.
REQ-019 Throughput SHALL be 2 cycles per word; for a start sampled at edge E0, done SHALL be high in cycle 2*len+1 after E0 (cycle 1 for len=0).
REQ-020 Address arithmetic src+i and dst+i SHALL be SIZE bits wide and wrap modulo 2**SIZE.
REQ-021 start SHALL be ignored in RD, WR and DONE, and input changes during a copy SHALL NOT affect it.
REQ-022 Overlapping regions SHALL be copied strictly in ascending order, word by word, with no hazard protection; for example, dst=src+1 replicates mem[src] across the range.
REQ-023 wrEn SHALL be asserted only in WR and SHALL never be high for more than one consecutive cycle.

Reset
REQ-024 While rst=0, the block SHALL force state=IDLE, i=0, busy=0, done=0, wrEn=0, addr_toRAM=0 and data_toRAM=0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-copy SHALL abort the copy with no further writes; words already written SHALL remain and no done pulse SHALL be issued.
REQ-026 After rst returns to 1, the block SHALL accept start on the first rising edge.

Verification
REQ-027 Basic copy: mem[100..102]=6,7,8, start with src=100, dst=200, len=3 -> mem[200..202]=6,7,8; exactly 3 wrEn pulses; done in cycle 7; mem[203] unchanged.
REQ-028 Zero length: start with len=0 -> done=1 in cycle 1; wrEn never asserted; busy never high.
REQ-029 Wrap-around: src=16382, dst=5, len=4, mem[16382,16383,0,1]=A,B,C,D -> mem[5..8]=A,B,C,D.
REQ-030 Overlap and ignore: mem[50]=9, src=50, dst=51, len=3, start held high throughout -> mem[51..53]=9,9,9; a second copy starts only after IDLE is re-entered.
REQ-031 Reset mid-copy: len=10 copy, rst=0 asynchronously (between edges) after the 3rd WR -> outputs read 0 before the next edge; exactly 3 destination words written; no done pulse; a new copy after release completes correctly.
